serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder computing {Cout,Sum} = A + B + Cin, one bit per cycle, LSB first.
// Latency: start accepted in cycle N -> done pulse in cycle N+WIDTH+1; minimum issue interval WIDTH+2.
// Backpressure: start_ready is high only in IDLE; start_valid seen in RUN or DONE is ignored.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Full-add slice built from two half-add cells.
  logic             s1;
  logic             c1;
  logic             c2;
  logic             bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;

  assign s1      = a_q[0] ^ b_q[0];
  assign c1      = a_q[0] & b_q[0];
  assign bit_d   = s1 ^ carry_q;
  assign c2      = s1 & carry_q;
  assign carry_d = c1 | c2;

  // New bit enters at the MSB; the oldest bit falls off the bottom.
  assign res_d   = WIDTH'({bit_d, res_q} >> 1);

  // Ready is suppressed while reset is held so nothing is accepted during reset.
  assign start_ready = (state_q == IDLE) && !rst;
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Control FSM plus datapath: capture on accept, shift per RUN cycle, publish result on RUN->DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
